seq_detect_fsm: RTL and testbench
=================================

Name: seq_detect_fsm

Overview:
- Parametrised serial pattern detector; successor to the single-bit FSM2 detector.
- Detects a runtime-programmable PAT_W-bit pattern on serial input x.
- Supports overlapping and non-overlapping modes, enable gating, and a saturating match counter.
- Sits on serial control streams feeding downstream FSM logic; outp is a registered one-cycle pulse per match.

Parameters:
- PAT_W, 4, pattern length in bits (range 2..16).
- CNT_W, 8, match counter width (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  detector enable; x is sampled only while en=1.
- x  input  1  serial data bit, one per enabled cycle.
- pattern  input  PAT_W  target pattern; MSB is the earliest bit; latched on enable.
- overlap  input  1  1=overlapping matches allowed; latched on enable.
- clr_count  input  1  synchronous clear of match_count and count_sat.
- outp  output  1  match pulse.
- match_count  output  CNT_W  number of matches, saturating.
- count_sat  output  1  sticky flag: counter has reached its maximum.

Behaviour:
- Reset (reset=0, async): state=S_IDLE, hist=0, fill=0, pat_q=0, ovl_q=0, outp=0, match_count=0, count_sat=0.
- States:
  - S_IDLE: en=0.
  - S_FILL: fewer than PAT_W valid bits held.
  - S_SCAN: history full.
- Transitions:
  - S_IDLE -> S_FILL when en=1. On that edge: pat_q<=pattern, ovl_q<=overlap, hist<=x (LSB), fill<=1. The same edge also samples x.
  - S_FILL -> S_SCAN when fill reaches PAT_W.
  - Any state -> S_IDLE when en=0. fill<=0; count is held; outp<=0 on the next edge.
- History: each enabled edge does hist<={hist[PAT_W-2:0],x}, fill<=min(fill+1,PAT_W).
- Match: match = (fill_next==PAT_W) && (hist_next==pat_q).
- Latency: outp<=match. outp is high for exactly the one cycle after the edge that samples the completing bit.
- Overlap mode (ovl_q=1): history is kept after a match. Back-to-back matches are possible for periodic patterns (e.g. 1111 on a run of 1s gives outp high on every edge).
- Non-overlap mode (ovl_q=0): a match forces fill<=0 and state S_FILL. The next match needs PAT_W fresh bits.
- pattern and overlap changes while en=1 are ignored until the next S_IDLE -> S_FILL entry.
- Counter:
  - On match, match_count increments unless it equals 2^CNT_W-1.
  - Reaching the maximum sets count_sat, which stays set until cleared.
  - clr_count=1 takes priority over a same-cycle increment: count<=0, count_sat<=0. outp is unaffected.
- Reset mid-stream: all history is discarded; no outp pulse is generated from partial history.
- Width rules:
  - fill is $clog2(PAT_W+1) bits.
  - All compares use PAT_W bits; there is no sign extension.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum typedef (S_IDLE, S_FILL, S_SCAN);
  - localparam function for the fill width.
- One natural sub-module: sat_counter (CNT_W, inc, clr -> count, sat), reused elsewhere.
- History shift, compare and FSM stay in seq_detect_fsm.

Test Plan:
1. Overlap: PAT_W=4, pattern=1011, overlap=1, en=1, x=1,0,1,1,0,1,1 -> outp pulses after the 4th and 7th bits; match_count=2.
2. Non-overlap: same stream, overlap=0 -> outp pulses only after the 4th bit; match_count=1.
3. Periodic overlap: pattern=1111, overlap=1, six 1s -> outp high for 3 consecutive cycles (bits 4, 5, 6); count=3. With overlap=0, only bit 4 produces a pulse; count=1.
4. Enable gap: pattern=1011, send 1,0, drop en one cycle, then send 1,1 -> no pulse, because fill restarts. Then send 0,1,1 after 1,1 -> still no pulse until 4 fresh bits match.
5. Saturation: CNT_W=2, 5 matches -> match_count=3, count_sat=1. Asserting clr_count on the same cycle as a match -> count=0, sat=0, outp still pulses.
6. Async reset: assert reset=0 mid-fill between clock edges -> outputs 0 immediately. Deassert, then send 0,1,1 -> no pulse (only 3 bits after reset).

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding and fill-counter sizing.
// Pure declarations; no logic, no latency, no flow control.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    // Fill must be able to hold the value PAT_W itself, hence +1.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_sat_counter.sv
// Saturating event counter with a sticky saturation flag; clear wins over increment.
// One-cycle update latency; free-running, no flow control.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc && (count_q != CNT_MAX)) begin
                count_d = count_q + 1'b1;
            end
            if (count_d == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// Serial PAT_W-bit pattern detector with overlap/non-overlap modes and a saturating match count.
// outp is a registered pulse one cycle after the edge sampling the completing bit; no backpressure.
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr_count,
    output logic             outp,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int             FW        = fill_width(PAT_W);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

    state_t           state_q, state_d;
    // Only the PAT_W-1 older bits are stored; the newest bit is always the live x.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic             outp_q, outp_d;

    logic [PAT_W-1:0] hist_nx;
    logic [FW-1:0]    fill_nx;
    logic             match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            outp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            outp_q  <= outp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        hist_nx = {hist_q, x};
        fill_nx = fill_q;
        match   = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            fill_d  = '0;
        end else begin
            if (state_q == S_IDLE) begin
                pat_d   = pattern;
                ovl_d   = overlap;
                hist_nx = {{(PAT_W-1){1'b0}}, x};
                fill_nx = FW'(1);
            end else begin
                hist_nx = {hist_q, x};
                fill_nx = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
            end
            // On the entry edge fill_nx is 1, so a stale pat_q can never match.
            match  = (fill_nx == FILL_FULL) && (hist_nx == pat_q);
            hist_d = hist_nx[PAT_W-2:0];
            if (match && !ovl_q) begin
                fill_d  = '0;
                state_d = S_FILL;
            end else begin
                fill_d  = fill_nx;
                state_d = (fill_nx == FILL_FULL) ? S_SCAN : S_FILL;
            end
        end
    end

    always_comb begin
        outp_d = match;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clr_count),
        .count (match_count),
        .sat   (count_sat)
    );

    assign outp = outp_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Vector-table and scoreboard bench for seq_detect_fsm (PAT_W=4, CNT_W=2 to reach saturation quickly).
module tb_seq_detect_fsm;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             x;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             clr_count;
    logic             outp;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    seq_detect_fsm #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .en          (en),
        .x           (x),
        .pattern     (pattern),
        .overlap     (overlap),
        .clr_count   (clr_count),
        .outp        (outp),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic             x;
        logic             clr;
        logic [PAT_W-1:0] pat;
        logic             ovl;
        logic             e_out;
        logic [CNT_W-1:0] e_cnt;
        logic             e_sat;
    } vec_t;

    typedef struct {
        logic             outp;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input logic e, input logic xi, input logic c,
                                input logic [PAT_W-1:0] p, input logic o,
                                input logic eo, input logic [CNT_W-1:0] ec, input logic es);
        vec_t v;
        v.en = e; v.x = xi; v.clr = c; v.pat = p; v.ovl = o;
        v.e_out = eo; v.e_cnt = ec; v.e_sat = es;
        vecs.push_back(v);
    endfunction

    function automatic void chk(input string nm, input int idx, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp_v);
        end
    endfunction

    // Pop one expectation and compare it with what the DUT shows right now.
    task automatic compare_now(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries, expected 1", idx);
        end else begin
            e = sb.pop_front();
            chk("outp", idx, int'(outp), int'(e.outp));
            chk("match_count", idx, int'(match_count), int'(e.cnt));
            chk("count_sat", idx, int'(count_sat), int'(e.sat));
        end
    endtask

    task automatic push_exp(input logic eo, input logic [CNT_W-1:0] ec, input logic es);
        exp_t e;
        e.outp = eo; e.cnt = ec; e.sat = es;
        sb.push_back(e);
    endtask

    task automatic step(input int idx, input logic e, input logic xi, input logic c,
                        input logic [PAT_W-1:0] p, input logic o,
                        input logic eo, input logic [CNT_W-1:0] ec, input logic es);
        @(negedge clk);
        en = e; x = xi; clr_count = c; pattern = p; overlap = o;
        push_exp(eo, ec, es);
        @(posedge clk);
        #1;
        compare_now(idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; x = 1'b0; clr_count = 1'b0;
        pattern = '0; overlap = 1'b0;

        // Overlap, pattern 1011, stream 1,0,1,1,0,1,1: pulses on bits 4 and 7.
        add(1,1,0,4'hB,1, 0,0,0); add(1,0,0,4'hB,1, 0,0,0);
        add(1,1,0,4'hB,1, 0,0,0); add(1,1,0,4'hB,1, 1,1,0);
        add(1,0,0,4'hB,1, 0,1,0); add(1,1,0,4'hB,1, 0,1,0);
        add(1,1,0,4'hB,1, 1,2,0); add(0,0,1,4'hB,1, 0,0,0);
        // Non-overlap, same stream: only bit 4.
        add(1,1,0,4'hB,0, 0,0,0); add(1,0,0,4'hB,0, 0,0,0);
        add(1,1,0,4'hB,0, 0,0,0); add(1,1,0,4'hB,0, 1,1,0);
        add(1,0,0,4'hB,0, 0,1,0); add(1,1,0,4'hB,0, 0,1,0);
        add(1,1,0,4'hB,0, 0,1,0); add(0,0,1,4'hB,0, 0,0,0);
        // Periodic 1111 overlap: three back-to-back pulses, counter reaches max.
        add(1,1,0,4'hF,1, 0,0,0); add(1,1,0,4'hF,1, 0,0,0);
        add(1,1,0,4'hF,1, 0,0,0); add(1,1,0,4'hF,1, 1,1,0);
        add(1,1,0,4'hF,1, 1,2,0); add(1,1,0,4'hF,1, 1,3,1);
        add(0,0,1,4'hF,1, 0,0,0);
        // Periodic 1111 non-overlap; pattern/overlap changed mid-run must be ignored.
        add(1,1,0,4'hF,0, 0,0,0); add(1,1,0,4'h0,1, 0,0,0);
        add(1,1,0,4'h0,1, 0,0,0); add(1,1,0,4'h0,1, 1,1,0);
        add(1,1,0,4'h0,1, 0,1,0); add(1,1,0,4'h0,1, 0,1,0);
        add(0,0,1,4'h0,1, 0,0,0);
        // Enable gap restarts fill; x during the gap is not sampled.
        add(1,1,0,4'hB,1, 0,0,0); add(1,0,0,4'hB,1, 0,0,0);
        add(0,1,0,4'hB,1, 0,0,0); add(1,1,0,4'hB,1, 0,0,0);
        add(1,1,0,4'hB,1, 0,0,0); add(1,0,0,4'hB,1, 0,0,0);
        add(1,1,0,4'hB,1, 0,0,0); add(1,1,0,4'hB,1, 1,1,0);
        add(0,0,1,4'hB,1, 0,0,0);
        // Saturation with five matches, then clear coinciding with a match.
        add(1,1,0,4'hF,1, 0,0,0); add(1,1,0,4'hF,1, 0,0,0);
        add(1,1,0,4'hF,1, 0,0,0); add(1,1,0,4'hF,1, 1,1,0);
        add(1,1,0,4'hF,1, 1,2,0); add(1,1,0,4'hF,1, 1,3,1);
        add(1,1,0,4'hF,1, 1,3,1); add(1,1,0,4'hF,1, 1,3,1);
        add(1,1,1,4'hF,1, 1,0,0); add(1,1,0,4'hF,1, 1,1,0);
        add(0,0,1,4'hF,1, 0,0,0);

        // Reset state, checked while reset is held and across an edge.
        #2;
        push_exp(1'b0, '0, 1'b0);
        compare_now(-1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(-2, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i].en, vecs[i].x, vecs[i].clr, vecs[i].pat, vecs[i].ovl,
                 vecs[i].e_out, vecs[i].e_cnt, vecs[i].e_sat);
        end

        // Async reset mid-stream: outputs clear before any edge, history is discarded.
        step(100, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0);
        step(101, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0);
        step(102, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0);
        step(103, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b1, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, '0, 1'b0);
        compare_now(104);
        @(posedge clk);
        #2;
        push_exp(1'b0, '0, 1'b0);
        compare_now(105);
        rst_n = 1'b1;
        // Without the reset, 1011 history + 0,1,1 would match on the last bit.
        step(106, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0);
        step(107, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0);
        step(108, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0);
        step(109, 1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
